// File: rtl/e203_lsu_thread_arb_pkg.sv
// e203_lsu_thread_arb_pkg
//   Shared definitions for the per-thread LSU AGU arbiter: thread count,
//   instruction tag width, the lock FSM state type and helpers for
//   addressing a thread's slice inside the flattened per-thread buses.
package e203_lsu_thread_arb_pkg;

  localparam int E203_THREADS_NUM = 2;
  localparam int E203_ITAG_WIDTH  = 1;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Low bit of thread idx's field in a bus of fields w bits wide.
  function automatic int thr_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // Thread index following idx, wrapping at n.
  function automatic int thr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/e203_lsu_arb_ostd_fifo.sv
// e203_lsu_arb_ostd_fifo
//   Synchronous FIFO holding the thread index of each outstanding
//   back2agu command, so responses can be steered back in issue order.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties FIFO)
//   i_push, i_din     write strobe and thread index
//   i_pop             read strobe (head advances)
//   o_head            thread index at the head
//   o_full, o_empty   occupancy flags
module e203_lsu_arb_ostd_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      // Simultaneous push and pop leaves the count unchanged.
      if (i_push && !i_pop)      r_cnt <= r_cnt + 1'b1;
      else if (i_pop && !i_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/e203_lsu_thread_arb.sv
// e203_lsu_thread_arb
//   Round-robin arbiter of per-thread AGU ICB command channels onto the
//   single LSU AGU command port. Holds the grant across locked (AMO)
//   sequences and routes back2agu responses to the issuing thread.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   t_cmd_*                   per-thread command channels (thread i = slice i)
//   agu_icb_cmd_*             muxed command to the LSU, thread_sel one-hot
//   agu_icb_rsp_*             LSU response channel
//   t_rsp_*                   routed response (one-hot valid, shared payload)
//   arb_err                   sticky: response with nothing outstanding
//   arb_active                clock-gate request
//
// state      | meaning
// ARB_OPEN   | round-robin grant starting at r_rr_ptr
// ARB_LOCKED | only r_owner may be granted until it hands off with lock=0
module e203_lsu_thread_arb
  import e203_lsu_thread_arb_pkg::*;
#(
  parameter int THREADS = E203_THREADS_NUM,
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int ITAG_W  = E203_ITAG_WIDTH,
  parameter int OSTD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [THREADS-1:0]       t_cmd_valid,
  output logic [THREADS-1:0]       t_cmd_ready,
  input  logic [THREADS*AW-1:0]    t_cmd_addr,
  input  logic [THREADS*XLEN-1:0]  t_cmd_wdata,
  input  logic [THREADS*XLEN/8-1:0] t_cmd_wmask,
  input  logic [THREADS*2-1:0]     t_cmd_size,
  input  logic [THREADS*ITAG_W-1:0] t_cmd_itag,
  input  logic [THREADS-1:0]       t_cmd_read,
  input  logic [THREADS-1:0]       t_cmd_lock,
  input  logic [THREADS-1:0]       t_cmd_excl,
  input  logic [THREADS-1:0]       t_cmd_back2agu,
  input  logic [THREADS-1:0]       t_cmd_usign,
  output logic                     agu_icb_cmd_valid,
  input  logic                     agu_icb_cmd_ready,
  output logic [AW-1:0]            agu_icb_cmd_addr,
  output logic                     agu_icb_cmd_read,
  output logic [XLEN-1:0]          agu_icb_cmd_wdata,
  output logic [XLEN/8-1:0]        agu_icb_cmd_wmask,
  output logic                     agu_icb_cmd_lock,
  output logic                     agu_icb_cmd_excl,
  output logic [1:0]               agu_icb_cmd_size,
  output logic                     agu_icb_cmd_back2agu,
  output logic                     agu_icb_cmd_usign,
  output logic [ITAG_W-1:0]        agu_icb_cmd_itag,
  output logic [THREADS-1:0]       agu_icb_cmd_thread_sel,
  input  logic                     agu_icb_rsp_valid,
  output logic                     agu_icb_rsp_ready,
  input  logic                     agu_icb_rsp_err,
  input  logic                     agu_icb_rsp_excl_ok,
  input  logic [XLEN-1:0]          agu_icb_rsp_rdata,
  output logic [THREADS-1:0]       t_rsp_valid,
  input  logic [THREADS-1:0]       t_rsp_ready,
  output logic                     t_rsp_err,
  output logic                     t_rsp_excl_ok,
  output logic [XLEN-1:0]          t_rsp_rdata,
  output logic                     arb_err,
  output logic                     arb_active
);

  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

  arb_state_e       r_state, w_state_nxt;
  logic [TW-1:0]    r_rr_ptr, w_rr_nxt;
  logic [TW-1:0]    r_owner, w_owner_nxt;
  logic             r_arb_err;

  logic [TW-1:0]    w_gnt;
  logic             w_gnt_vld;
  logic [THREADS-1:0] w_sel;
  logic             w_stall;
  logic             w_cmd_go;
  logic             w_cmd_hs;
  logic             w_push, w_pop;
  logic [TW-1:0]    w_head;
  logic             w_full, w_empty;

  // Grant: owner only while locked, else first valid thread from r_rr_ptr.
  always_comb begin
    int idx;
    w_gnt     = r_rr_ptr;
    w_gnt_vld = 1'b0;
    idx       = 0;
    if (r_state == ARB_LOCKED) begin
      w_gnt     = r_owner;
      w_gnt_vld = t_cmd_valid[r_owner];
    end else begin
      for (int k = 0; k < THREADS; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= THREADS) idx = idx - THREADS;
        if (!w_gnt_vld && t_cmd_valid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = TW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    if (w_gnt_vld) w_sel[w_gnt] = 1'b1;
  end

  // Stall looks only at the registered full flag, never at a same-cycle pop.
  assign w_stall  = w_gnt_vld & t_cmd_back2agu[w_gnt] & w_full;
  assign w_cmd_go = ~rst & ~w_stall & agu_icb_cmd_ready;

  assign agu_icb_cmd_valid      = ~rst & w_gnt_vld & ~w_stall;
  assign t_cmd_ready            = w_sel & {THREADS{w_cmd_go}};
  assign agu_icb_cmd_thread_sel = rst ? '0 : w_sel;
  assign w_cmd_hs               = agu_icb_cmd_valid & agu_icb_cmd_ready;

  assign agu_icb_cmd_addr     = t_cmd_addr[thr_lo(int'(w_gnt), AW) +: AW];
  assign agu_icb_cmd_wdata    = t_cmd_wdata[thr_lo(int'(w_gnt), XLEN) +: XLEN];
  assign agu_icb_cmd_wmask    = t_cmd_wmask[thr_lo(int'(w_gnt), XLEN/8) +: XLEN/8];
  assign agu_icb_cmd_size     = t_cmd_size[thr_lo(int'(w_gnt), 2) +: 2];
  assign agu_icb_cmd_itag     = t_cmd_itag[thr_lo(int'(w_gnt), ITAG_W) +: ITAG_W];
  assign agu_icb_cmd_read     = t_cmd_read[w_gnt];
  assign agu_icb_cmd_lock     = t_cmd_lock[w_gnt];
  assign agu_icb_cmd_excl     = t_cmd_excl[w_gnt];
  assign agu_icb_cmd_back2agu = t_cmd_back2agu[w_gnt];
  assign agu_icb_cmd_usign    = t_cmd_usign[w_gnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_OPEN;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // While locked the grant is the owner, so a lock=0 handshake here is
  // always the owner handing off and the pointer moves past it.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    if (w_cmd_hs) begin
      if (agu_icb_cmd_lock) begin
        w_state_nxt = ARB_LOCKED;
        w_owner_nxt = w_gnt;
      end else begin
        w_state_nxt = ARB_OPEN;
        w_rr_nxt    = TW'(thr_next(int'(w_gnt), THREADS));
      end
    end
  end

  assign w_push = w_cmd_hs & agu_icb_cmd_back2agu;
  assign w_pop  = agu_icb_rsp_valid & agu_icb_rsp_ready & ~w_empty;

  e203_lsu_arb_ostd_fifo #(
    .DEPTH (OSTD),
    .DW    (TW)
  ) u_ostd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_gnt),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // With nothing outstanding the response is accepted and dropped.
  always_comb begin
    t_rsp_valid = '0;
    if (!rst && !w_empty) t_rsp_valid[w_head] = agu_icb_rsp_valid;
  end

  assign agu_icb_rsp_ready = ~rst & (w_empty | t_rsp_ready[w_head]);
  assign t_rsp_err         = agu_icb_rsp_err;
  assign t_rsp_excl_ok     = agu_icb_rsp_excl_ok;
  assign t_rsp_rdata       = agu_icb_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_arb_err <= 1'b0;
    else if (agu_icb_rsp_valid && w_empty) r_arb_err <= 1'b1;
  end

  assign arb_err    = r_arb_err;
  assign arb_active = (|t_cmd_valid) | ~w_empty | (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_e203_lsu_thread_arb.sv
module tb_e203_lsu_thread_arb;

  localparam int T    = 2;
  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int IW   = 1;
  localparam int OSTD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [T-1:0]        t_cmd_valid, t_cmd_ready;
  logic [T*AW-1:0]     t_cmd_addr;
  logic [T*XLEN-1:0]   t_cmd_wdata;
  logic [T*XLEN/8-1:0] t_cmd_wmask;
  logic [T*2-1:0]      t_cmd_size;
  logic [T*IW-1:0]     t_cmd_itag;
  logic [T-1:0]        t_cmd_read, t_cmd_lock, t_cmd_excl, t_cmd_back2agu, t_cmd_usign;
  logic                agu_icb_cmd_valid, agu_icb_cmd_ready;
  logic [AW-1:0]       agu_icb_cmd_addr;
  logic                agu_icb_cmd_read;
  logic [XLEN-1:0]     agu_icb_cmd_wdata;
  logic [XLEN/8-1:0]   agu_icb_cmd_wmask;
  logic                agu_icb_cmd_lock, agu_icb_cmd_excl;
  logic [1:0]          agu_icb_cmd_size;
  logic                agu_icb_cmd_back2agu, agu_icb_cmd_usign;
  logic [IW-1:0]       agu_icb_cmd_itag;
  logic [T-1:0]        agu_icb_cmd_thread_sel;
  logic                agu_icb_rsp_valid, agu_icb_rsp_ready;
  logic                agu_icb_rsp_err, agu_icb_rsp_excl_ok;
  logic [XLEN-1:0]     agu_icb_rsp_rdata;
  logic [T-1:0]        t_rsp_valid, t_rsp_ready;
  logic                t_rsp_err, t_rsp_excl_ok;
  logic [XLEN-1:0]     t_rsp_rdata;
  logic                arb_err, arb_active;

  e203_lsu_thread_arb #(
    .THREADS(T), .XLEN(XLEN), .AW(AW), .ITAG_W(IW), .OSTD(OSTD)
  ) dut (
    .clk(clk), .rst(rst),
    .t_cmd_valid(t_cmd_valid), .t_cmd_ready(t_cmd_ready),
    .t_cmd_addr(t_cmd_addr), .t_cmd_wdata(t_cmd_wdata), .t_cmd_wmask(t_cmd_wmask),
    .t_cmd_size(t_cmd_size), .t_cmd_itag(t_cmd_itag),
    .t_cmd_read(t_cmd_read), .t_cmd_lock(t_cmd_lock), .t_cmd_excl(t_cmd_excl),
    .t_cmd_back2agu(t_cmd_back2agu), .t_cmd_usign(t_cmd_usign),
    .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
    .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
    .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
    .agu_icb_cmd_lock(agu_icb_cmd_lock), .agu_icb_cmd_excl(agu_icb_cmd_excl),
    .agu_icb_cmd_size(agu_icb_cmd_size), .agu_icb_cmd_back2agu(agu_icb_cmd_back2agu),
    .agu_icb_cmd_usign(agu_icb_cmd_usign), .agu_icb_cmd_itag(agu_icb_cmd_itag),
    .agu_icb_cmd_thread_sel(agu_icb_cmd_thread_sel),
    .agu_icb_rsp_valid(agu_icb_rsp_valid), .agu_icb_rsp_ready(agu_icb_rsp_ready),
    .agu_icb_rsp_err(agu_icb_rsp_err), .agu_icb_rsp_excl_ok(agu_icb_rsp_excl_ok),
    .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
    .t_rsp_valid(t_rsp_valid), .t_rsp_ready(t_rsp_ready),
    .t_rsp_err(t_rsp_err), .t_rsp_excl_ok(t_rsp_excl_ok), .t_rsp_rdata(t_rsp_rdata),
    .arb_err(arb_err), .arb_active(arb_active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: thread-level view of the arbiter.
  int  m_rr     = 0;
  bit  m_locked = 1'b0;
  int  m_owner  = 0;
  bit  m_err    = 1'b0;
  int  m_q[$];

  // Observations from the most recent cycle, for directed constant checks.
  logic [T-1:0]    obs_sel, obs_ready, obs_rspv;
  logic            obs_cmdv, obs_rsp_ready, obs_err, obs_active;
  logic [XLEN-1:0] obs_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the combinational outputs mid-cycle against the model, then
  // advances the model across the next rising edge.
  task automatic cycle(input string tag);
    int g;
    bit gv, stall, cv, hs, rr, pop;
    logic [T-1:0] es, er, erv;
    @(negedge clk);
    gv = 1'b0;
    g  = 0;
    if (m_locked) begin
      g  = m_owner;
      gv = t_cmd_valid[g];
    end else begin
      for (int k = 0; k < T; k++) begin
        if (!gv && t_cmd_valid[(m_rr + k) % T]) begin
          gv = 1'b1;
          g  = (m_rr + k) % T;
        end
      end
    end
    stall = gv && t_cmd_back2agu[g] && (m_q.size() == OSTD);
    cv    = gv && !stall && !rst;
    hs    = cv && agu_icb_cmd_ready;
    es = '0;
    er = '0;
    if (gv && !rst) es[g] = 1'b1;
    if (hs) er[g] = 1'b1;
    erv = '0;
    if (rst) rr = 1'b0;
    else if (m_q.size() > 0) begin
      rr = t_rsp_ready[m_q[0]];
      if (agu_icb_rsp_valid) erv[m_q[0]] = 1'b1;
    end else rr = 1'b1;

    obs_sel = agu_icb_cmd_thread_sel;  obs_ready = t_cmd_ready;
    obs_rspv = t_rsp_valid;            obs_cmdv = agu_icb_cmd_valid;
    obs_rsp_ready = agu_icb_rsp_ready; obs_err = arb_err;
    obs_active = arb_active;           obs_rdata = t_rsp_rdata;

    chk({tag, ".cmd_valid"}, 64'(agu_icb_cmd_valid), 64'(cv));
    chk({tag, ".t_cmd_ready"}, 64'(t_cmd_ready), 64'(er));
    chk({tag, ".thread_sel"}, 64'(agu_icb_cmd_thread_sel), 64'(es));
    if (cv) begin
      chk({tag, ".cmd_addr"}, 64'(agu_icb_cmd_addr), 64'(t_cmd_addr[g*AW +: AW]));
      chk({tag, ".cmd_b2a"}, 64'(agu_icb_cmd_back2agu), 64'(t_cmd_back2agu[g]));
      chk({tag, ".cmd_lock"}, 64'(agu_icb_cmd_lock), 64'(t_cmd_lock[g]));
    end
    chk({tag, ".t_rsp_valid"}, 64'(t_rsp_valid), 64'(erv));
    chk({tag, ".rsp_ready"}, 64'(agu_icb_rsp_ready), 64'(rr));
    chk({tag, ".rsp_rdata"}, 64'(t_rsp_rdata), 64'(agu_icb_rsp_rdata));
    chk({tag, ".arb_err"}, 64'(arb_err), 64'(m_err));
    chk({tag, ".arb_active"}, 64'(arb_active),
        64'((|t_cmd_valid) || (m_q.size() > 0) || m_locked));

    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_locked = 1'b0; m_owner = 0; m_err = 1'b0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && agu_icb_rsp_valid && rr;
      if (agu_icb_rsp_valid && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        if (t_cmd_back2agu[g]) m_q.push_back(g);
        if (t_cmd_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
        end else begin
          m_locked = 1'b0;
          m_rr     = (g + 1) % T;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    t_cmd_valid = '0; t_cmd_lock = '0; t_cmd_back2agu = '0;
    t_cmd_read = '0; t_cmd_excl = '0; t_cmd_usign = '0;
    agu_icb_cmd_ready = 1'b1; agu_icb_rsp_valid = 1'b0;
    t_rsp_ready = '1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    t_cmd_addr = {32'h0000_1111, 32'h8000_0000};
    t_cmd_wdata = {32'h2222_2222, 32'h1111_1111};
    t_cmd_wmask = '1; t_cmd_size = '0; t_cmd_itag = '0;
    agu_icb_rsp_err = 1'b0; agu_icb_rsp_excl_ok = 1'b0; agu_icb_rsp_rdata = '0;
    @(posedge clk); #1;

    // Reset state with requests pending.
    t_cmd_valid = 2'b11;
    cycle("rst");
    chk("rst.sel_zero", 64'(obs_sel), 64'(0));
    chk("rst.cmdv_zero", 64'(obs_cmdv), 64'(0));
    rst = 1'b0;

    // Round-robin fairness.
    cycle("rr0"); chk("rr0.sel", 64'(obs_sel), 64'(2'b01));
    cycle("rr1"); chk("rr1.sel", 64'(obs_sel), 64'(2'b10));
    cycle("rr2"); chk("rr2.sel", 64'(obs_sel), 64'(2'b01));
    cycle("rr3"); chk("rr3.sel", 64'(obs_sel), 64'(2'b10));

    // Lock hold by thread 1.
    t_cmd_valid = 2'b10; t_cmd_lock = 2'b10;
    cycle("lk0");
    t_cmd_valid = 2'b11;
    cycle("lk1"); chk("lk1.t0_ready", 64'(obs_ready[0]), 64'(0));
    cycle("lk2"); chk("lk2.t0_ready", 64'(obs_ready[0]), 64'(0));
    t_cmd_lock = 2'b00;
    cycle("lk3"); chk("lk3.sel", 64'(obs_sel), 64'(2'b10));
    cycle("lk4"); chk("lk4.sel", 64'(obs_sel), 64'(2'b01));
    idle_inputs();

    // Response routing.
    t_cmd_valid = 2'b01; t_cmd_back2agu = 2'b01;
    cycle("rt0");
    t_cmd_valid = 2'b10; t_cmd_back2agu = 2'b10;
    cycle("rt1");
    idle_inputs();
    agu_icb_rsp_valid = 1'b1; agu_icb_rsp_rdata = 32'h0000_AAAA;
    cycle("rt2");
    chk("rt2.rspv", 64'(obs_rspv), 64'(2'b01));
    chk("rt2.rdata", 64'(obs_rdata), 64'(32'h0000_AAAA));
    agu_icb_rsp_rdata = 32'h0000_5555;
    cycle("rt3");
    chk("rt3.rspv", 64'(obs_rspv), 64'(2'b10));
    chk("rt3.rdata", 64'(obs_rdata), 64'(32'h0000_5555));
    idle_inputs();

    // FIFO full stall.
    t_cmd_valid = 2'b01; t_cmd_back2agu = 2'b01;
    cycle("fs0"); cycle("fs1");
    cycle("fs2"); chk("fs2.stall", 64'(obs_cmdv), 64'(0));
    t_cmd_valid = 2'b11;
    cycle("fs3");
    chk("fs3.other_cmdv", 64'(obs_cmdv), 64'(1));
    chk("fs3.other_sel", 64'(obs_sel), 64'(2'b10));
    t_cmd_valid = 2'b01; agu_icb_rsp_valid = 1'b1;
    cycle("fs4"); chk("fs4.stall_on_pop", 64'(obs_cmdv), 64'(0));
    agu_icb_rsp_valid = 1'b0;
    cycle("fs5"); chk("fs5.released", 64'(obs_cmdv), 64'(1));
    idle_inputs();
    agu_icb_rsp_valid = 1'b1;
    cycle("fs6"); cycle("fs7");
    idle_inputs();

    // Backpressure, then spurious response.
    t_cmd_valid = 2'b01; t_cmd_back2agu = 2'b01;
    cycle("bp0");
    idle_inputs();
    agu_icb_rsp_valid = 1'b1; t_rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp_hold.rsp_ready", 64'(obs_rsp_ready), 64'(0));
    end
    t_rsp_ready = 2'b11;
    cycle("bp_pop"); chk("bp_pop.rspv", 64'(obs_rspv), 64'(2'b01));
    cycle("sp0");
    chk("sp0.rsp_ready", 64'(obs_rsp_ready), 64'(1));
    chk("sp0.rspv", 64'(obs_rspv), 64'(0));
    agu_icb_rsp_valid = 1'b0;
    cycle("sp1"); chk("sp1.arb_err", 64'(obs_err), 64'(1));
    cycle("sp2"); chk("sp2.arb_err", 64'(obs_err), 64'(1));

    // Reset while locked with two outstanding.
    t_cmd_valid = 2'b01; t_cmd_back2agu = 2'b01; t_cmd_lock = 2'b01;
    cycle("rl0"); cycle("rl1");
    rst = 1'b1; t_cmd_valid = 2'b11; agu_icb_rsp_valid = 1'b1;
    cycle("rl_rst");
    chk("rl_rst.cmdv", 64'(obs_cmdv), 64'(0));
    chk("rl_rst.ready", 64'(obs_ready), 64'(0));
    chk("rl_rst.rspv", 64'(obs_rspv), 64'(0));
    chk("rl_rst.rsp_ready", 64'(obs_rsp_ready), 64'(0));
    rst = 1'b0;
    idle_inputs();
    cycle("rl2");
    chk("rl2.arb_err", 64'(obs_err), 64'(0));
    chk("rl2.active", 64'(obs_active), 64'(0));
    t_cmd_valid = 2'b11;
    cycle("rl3"); chk("rl3.sel", 64'(obs_sel), 64'(2'b01));
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 99) == 0);
      t_cmd_valid       = T'($urandom);
      t_cmd_back2agu    = T'($urandom);
      t_cmd_lock[0]     = ($urandom_range(0, 5) == 0);
      t_cmd_lock[1]     = ($urandom_range(0, 5) == 0);
      t_cmd_read        = T'($urandom);
      t_cmd_addr        = {$urandom, $urandom};
      agu_icb_cmd_ready = ($urandom_range(0, 3) != 0);
      agu_icb_rsp_valid = ($urandom_range(0, 9) < 4);
      agu_icb_rsp_rdata = $urandom;
      t_rsp_ready       = T'($urandom);
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
